// File: rtl/reg_rr_arbiter_pkg.sv
// reg_arb_pkg: shared types and defaults for the registered round-robin arbiter
//   state_e   : output-register occupancy (EMPTY / FULL)
//   DEF_WIDTH : default payload width
//   DEF_NREQ  : default requester count
//   CNT_W     : width of the completed-grant counter
package reg_arb_pkg;
   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;
   localparam int DEF_WIDTH = 8;
   localparam int DEF_NREQ  = 4;
   localparam int CNT_W     = 16;
endpackage

// File: rtl/reg_rr_arbiter_slice.sv
// reg_rr_arbiter_slice: enable-gated register with asynchronous clear
//   clk, reset_n : clock, async active-low reset (clears q to zero)
//   en           : load d into q on the rising edge
//   d / q        : W-bit data in / registered data out
module reg_rr_arbiter_slice #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) q <= '0;
      else if (en)  q <= d;
endmodule

// File: rtl/reg_rr_arbiter.sv
// reg_rr_arbiter: round-robin arbiter feeding a one-entry registered output stage
//   clk, reset_n : clock, async active-low reset
//   req, data    : per-requester request and WIDTH-bit payload slices
//   gnt          : one-hot combinational grant (payload captured on that edge)
//   out_ready    : downstream accepts the held word
//   out_valid    : outa/out_id hold an unconsumed word
//   outa, out_id : captured payload and index of its requester
//   xfer_cnt     : completed-grant counter, wraps
module reg_rr_arbiter
   import reg_arb_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int NREQ  = DEF_NREQ,
   parameter int IDW   = $clog2(NREQ)
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*WIDTH-1:0] data,
   output logic [NREQ-1:0]       gnt,
   input  logic                  out_ready,
   output logic                  out_valid,
   output logic [WIDTH-1:0]      outa,
   output logic [IDW-1:0]        out_id,
   output logic [CNT_W-1:0]      xfer_cnt
);
   state_e           state_q, state_d;
   logic [IDW-1:0]   ptr_q, ptr_d, win, idx;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             found, grant_en;

   always_comb begin
      win   = '0;
      idx   = '0;
      found = 1'b0;
      // Scan offsets from highest to lowest so the nearest set bit at or above ptr wins last.
      for (int k = NREQ - 1; k >= 0; k--) begin
         idx = IDW'((int'(ptr_q) + k) % NREQ);
         if (req[idx]) begin
            win   = idx;
            found = 1'b1;
         end
      end
      // reset_n gates the grant so gnt stays zero while reset is held, independent of clk.
      grant_en = reset_n && (state_q == EMPTY || out_ready);
      gnt      = (grant_en && found) ? {{(NREQ-1){1'b0}}, 1'b1} << win : '0;
      state_d  = (|gnt) ? FULL : (out_ready ? EMPTY : state_q);
      ptr_d    = (|gnt) ? ((win == IDW'(NREQ - 1)) ? '0 : win + 1'b1) : ptr_q;
      cnt_d    = cnt_q + CNT_W'(|gnt);
   end

   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         state_q <= EMPTY;
         ptr_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
      end

   reg_rr_arbiter_slice #(.W(IDW + WIDTH)) u_slice (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (|gnt),
      .d       ({win, data[win*WIDTH +: WIDTH]}),
      .q       ({out_id, outa})
   );

   assign out_valid = (state_q == FULL);
   assign xfer_cnt  = cnt_q;
endmodule

// File: tb/tb_reg_rr_arbiter.sv
// tb_reg_rr_arbiter: randomized and directed checks of reg_rr_arbiter against a behavioural model
module tb_reg_rr_arbiter;
   logic        clk = 1'b0;
   logic        reset_n;
   logic [3:0]  req;
   logic [31:0] data;
   logic [3:0]  gnt;
   logic        out_ready;
   logic        out_valid;
   logic [7:0]  outa;
   logic [1:0]  out_id;
   logic [15:0] xfer_cnt;

   int vectors = 0;
   int miscompares = 0;

   int m_ptr, m_id, m_outa, m_cnt, last_w;
   bit m_full;
   int waits [4];

   always #5 clk = ~clk;

   reg_rr_arbiter dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .req       (req),
      .data      (data),
      .gnt       (gnt),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .outa      (outa),
      .out_id    (out_id),
      .xfer_cnt  (xfer_cnt)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_ptr = 0; m_id = 0; m_outa = 0; m_cnt = 0; m_full = 0; last_w = -1;
      for (int i = 0; i < 4; i++) waits[i] = 0;
   endtask

   // One clock: predict the grant from the requester ring, check it, then check the registered outputs.
   task automatic step();
      int w;
      #1;
      w = -1;
      if (!m_full || out_ready)
         for (int k = 0; k < 4 && w < 0; k++)
            if (req[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
      check("gnt", {28'd0, gnt}, (w < 0) ? 32'd0 : (32'd1 << w));
      @(posedge clk);
      if (w >= 0) begin
         m_outa = data[w*8 +: 8];
         m_id   = w;
         m_ptr  = (w + 1) % 4;
         m_cnt  = (m_cnt + 1) % 65536;
         m_full = 1;
         for (int i = 0; i < 4; i++) waits[i] = (i == w || !req[i]) ? 0 : waits[i] + 1;
      end else if (m_full && out_ready) m_full = 0;
      last_w = w;
      #1;
      check("out_valid", {31'd0, out_valid}, {31'd0, m_full});
      check("outa", {24'd0, outa}, m_outa);
      check("out_id", {30'd0, out_id}, m_id);
      check("xfer_cnt", {16'd0, xfer_cnt}, m_cnt);
   endtask

   initial begin
      int exp_seq [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
      int n;
      reset_n = 1'b0; req = 4'b1111; out_ready = 1'b1; data = 32'h44332211;
      model_reset();
      #3;
      check("rst_gnt", {28'd0, gnt}, 0);
      check("rst_valid", {31'd0, out_valid}, 0);
      check("rst_outa", {24'd0, outa}, 0);
      check("rst_cnt", {16'd0, xfer_cnt}, 0);
      repeat (2) @(posedge clk);
      #1;
      check("rst_gnt_clk", {28'd0, gnt}, 0);
      check("rst_outa_clk", {24'd0, outa}, 0);
      reset_n = 1'b1;

      for (int i = 0; i < 5; i++) begin
         step();
         check("rr_outa", {24'd0, outa}, exp_seq[i]);
         check("rr_id", {30'd0, out_id}, i % 4);
      end

      step();
      check("bp_setup", {24'd0, outa}, 8'h22);
      out_ready = 1'b0; req = 4'b0101;
      for (int i = 0; i < 5; i++) begin
         step();
         check("bp_outa", {24'd0, outa}, 8'h22);
         check("bp_cnt", {16'd0, xfer_cnt}, 6);
      end
      out_ready = 1'b1;
      step();
      check("bp_release_id", {30'd0, out_id}, 2);

      req = 4'b0001;
      #1;
      check("wrap_gnt", {28'd0, gnt}, 4'b0001);
      step();
      check("wrap_id", {30'd0, out_id}, 0);

      req = 4'b0010;
      step();
      req = 4'b0000; out_ready = 1'b0;
      #2 reset_n = 1'b0;
      #1;
      check("midrst_valid", {31'd0, out_valid}, 0);
      check("midrst_outa", {24'd0, outa}, 0);
      model_reset();
      #1 reset_n = 1'b1;
      req = 4'b0110; out_ready = 1'b1;
      step();
      check("midrst_id", {30'd0, out_id}, 1);

      req = 4'b0000;
      for (int c = 0; c < 3000; c++) begin
         if (last_w >= 0) req[last_w] = 1'b0;
         for (int i = 0; i < 4; i++)
            if (!req[i] && $urandom_range(1) == 1) begin
               req[i] = 1'b1;
               data[i*8 +: 8] = 8'($urandom);
            end
         out_ready = ($urandom_range(3) != 0);
         step();
         for (int i = 0; i < 4; i++) check("starve", {31'd0, waits[i] >= 4}, 0);
      end

      req = 4'b1111; out_ready = 1'b1;
      n = 0;
      while (m_cnt != 16'hFFFF && n < 70000) begin
         step();
         n++;
      end
      check("cnt_preload", {16'd0, xfer_cnt}, 16'hFFFF);
      step();
      check("cnt_wrap", {16'd0, xfer_cnt}, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/reg_rr_arbiter.md
REG_RR_ARBITER -- requirements
Module: reg_rr_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning data width of each requester and of the output.
REQ-002 The block SHALL have parameter NREQ, default 4, meaning number of requesters, legal range 2..8.
REQ-003 The block SHALL have parameter IDW, default $clog2(NREQ), meaning width of the winner ID.
REQ-004 clk  input  1  clock; all state changes on posedge.
REQ-005 reset_n  input  1  reset; asynchronous, active-low.
REQ-006 req  input  NREQ  per-requester request; bit i held high until gnt[i] is sampled high.
REQ-007 data  input  NREQ*WIDTH  per-requester payload; slice i is data[i*WIDTH +: WIDTH], stable while req[i] is high.
REQ-008 gnt  output  NREQ  one-hot combinational grant; data of the granted requester is captured on that edge.
REQ-009 out_ready  input  1  downstream accepts outa when out_valid is high.
REQ-010 out_valid  output  1  outa/out_id hold a captured, unconsumed word.
REQ-011 outa  output  WIDTH  captured payload.
REQ-012 out_id  output  IDW  index of the requester whose payload is in outa.
REQ-013 xfer_cnt  output  16  count of completed grants, wraps 0xFFFF -> 0x0000.

Function
REQ-014 FSM SHALL have two states: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-015 Grant enable SHALL be (state==EMPTY) or (state==FULL and out_ready); gnt SHALL be all-zero otherwise.
REQ-016 When grant enabled and req nonzero, exactly one gnt bit SHALL be high: first set req bit searching from pointer ptr upward, wrapping NREQ-1 -> 0.
REQ-017 On an edge with gnt[i]=1: outa <= data slice i, out_id <= i, ptr <= (i+1) mod NREQ, xfer_cnt increments, state -> FULL.
REQ-018 Latency: payload SHALL appear on outa with out_valid=1 exactly one cycle after the granting edge.
REQ-019 FULL with out_ready=1 and req=0 SHALL go to EMPTY; outa/out_id SHALL retain their last values.
REQ-020 FULL with out_ready=1 and req nonzero SHALL stay FULL, loading the new winner (back-to-back, one word per cycle).
REQ-021 FULL with out_ready=0 SHALL hold outa, out_id, out_valid, ptr and xfer_cnt unchanged; gnt=0.
REQ-022 ptr SHALL change only on a grant; requests dropped without grant SHALL not affect ptr.
REQ-023 A requester with req continuously high SHALL be granted within NREQ grants (no starvation).
REQ-024 req bits set for indices >= NREQ do not exist; no X SHALL propagate from unused ID codes.

Reset
REQ-025 While reset_n=0: state=EMPTY, out_valid=0, outa=0, out_id=0, ptr=0, xfer_cnt=0, gnt=0, regardless of clk.
REQ-026 Reset asserted mid-transfer SHALL discard the held word; first grant after release SHALL start from ptr=0.
REQ-027 Deassertion SHALL be synchronised externally; first grant possible on first posedge after release.

Structure
REQ-028 Package reg_arb_pkg SHALL hold the state enum (EMPTY, FULL), default WIDTH/NREQ and the counter width constant.
REQ-029 The payload/ID storage SHALL be an instance of the team's register slice (enable = |gnt, async reset to zero); arbitration and FSM stay in reg_rr_arbiter.

Verification
REQ-030 Reset: hold reset_n=0 with req=4'b1111 -> gnt=0, out_valid=0, outa=0, xfer_cnt=0.
REQ-031 Round robin: req=4'b1111, out_ready=1, data={0x44,0x33,0x22,0x11} -> outa sequence 0x11,0x22,0x33,0x44,0x11 on consecutive cycles, out_id 0,1,2,3,0.
REQ-032 Backpressure: FULL with outa=0x22, out_ready=0 for 5 cycles, req=4'b0101 -> gnt=0, outa=0x22 held, xfer_cnt unchanged; release -> next winner id 2.
REQ-033 Wrap: ptr=3, req=4'b0001 -> gnt=4'b0001, out_id=0, ptr becomes 1.
REQ-034 Mid-op reset: out_valid=1, ptr=2, pulse reset_n low between edges -> out_valid=0 immediately; after release req=4'b0110 grants id 1.
REQ-035 Counter wrap: preload 0xFFFF grants (or force), one more grant -> xfer_cnt=0x0000.
